// File: rtl/gqed_pair_monitor.sv
// gqed_pair_monitor
//
// Pair monitor that sits between two copies of an HLS workload. It feeds both
// copies' single-port memory interfaces with read data from one shared
// sequence. It counts reads and writes per copy, and captures a CMP_LEN-element
// window of each copy's writes. It flags a functional-consistency failure when
// the two windows differ.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous re-arm (counters, captures, done flags)
//   seq               shared sequence, element k at [k*DATA_W +: DATA_W]
//   idx               copy-1 window start (held stable while armed)
//   free_in           copy-1 read data on cycles with no read response
//   c1_ce/we/addr/d   copy-1 memory request; c1_q is its read data
//   c2_ce/we/d        copy-2 memory request; c2_q is its read data
//   c2_hold           copy-2 start must be held low
//   done1, done2      window captured for copy 1 / copy 2
//   mismatch          per-element window inequality (valid when both done)
//   fc_fail           both done and at least one element differs
module gqed_pair_monitor #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int CMP_LEN = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clr,
   input  logic [(2**ADDR_W)*DATA_W-1:0]  seq,
   input  logic [ADDR_W-1:0]              idx,
   input  logic [DATA_W-1:0]              free_in,
   input  logic                           c1_ce,
   input  logic                           c1_we,
   input  logic [ADDR_W-1:0]              c1_addr,
   input  logic [DATA_W-1:0]              c1_d,
   output logic [DATA_W-1:0]              c1_q,
   input  logic                           c2_ce,
   input  logic                           c2_we,
   input  logic [DATA_W-1:0]              c2_d,
   output logic [DATA_W-1:0]              c2_q,
   output logic                           c2_hold,
   output logic                           done1,
   output logic                           done2,
   output logic [CMP_LEN-1:0]             mismatch,
   output logic                           fc_fail
);

   localparam int SEQ_LEN = 2**ADDR_W;
   localparam int CNT_W   = ADDR_W + 1;

   localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX_C  = '1;
   localparam logic [CNT_W-1:0] CMP_LEN_C  = CNT_W'(CMP_LEN);
   localparam logic [CNT_W-1:0] CMP_LAST_C = CNT_W'(CMP_LEN - 1);

   genvar gi;

   // Unpack the flat sequence so it can be indexed by address.
   logic [DATA_W-1:0] seq_arr [SEQ_LEN];
   generate
      for (gi = 0; gi < SEQ_LEN; gi++) begin : g_seq
         assign seq_arr[gi] = seq[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // One-cycle-delayed samples of the port requests. Every count and capture
   // uses these, which lines up with the workload's one-cycle read latency.
   logic              c1_ce_s_q, c1_ce_s_d;
   logic              c1_we_s_q, c1_we_s_d;
   logic [ADDR_W-1:0] c1_addr_s_q, c1_addr_s_d;
   logic [DATA_W-1:0] c1_d_s_q, c1_d_s_d;
   logic              c2_ce_s_q, c2_ce_s_d;
   logic              c2_we_s_q, c2_we_s_d;
   logic [DATA_W-1:0] c2_d_s_q, c2_d_s_d;

   logic [CNT_W-1:0]  c1_rd_cnt_q, c1_rd_cnt_d;
   logic [CNT_W-1:0]  c2_rd_cnt_q, c2_rd_cnt_d;
   logic [CNT_W-1:0]  c1_wr_cnt_q, c1_wr_cnt_d;
   logic [CNT_W-1:0]  c2_wr_cnt_q, c2_wr_cnt_d;
   logic              done1_q, done1_d;
   logic              done2_q, done2_d;

   logic              c1_rd, c1_wr, c2_rd, c2_wr;
   logic [CNT_W-1:0]  idx_ext, c1_lim, c1_last;
   logic [ADDR_W-1:0] c2_addr;
   logic              both_done;

   assign c1_rd   = c1_ce_s_q && !c1_we_s_q;
   assign c1_wr   = c1_ce_s_q &&  c1_we_s_q;
   assign c2_rd   = c2_ce_s_q && !c2_we_s_q;
   assign c2_wr   = c2_ce_s_q &&  c2_we_s_q;

   // CNT_W-bit arithmetic: idx + CMP_LEN cannot overflow.
   assign idx_ext = {1'b0, idx};
   assign c1_lim  = idx_ext + CMP_LEN_C;
   assign c1_last = c1_lim - ONE_C;

   always_comb begin
      c1_ce_s_d   = c1_ce;
      c1_we_s_d   = c1_we;
      c1_addr_s_d = c1_addr;
      c1_d_s_d    = c1_d;
      c2_ce_s_d   = c2_ce;
      c2_we_s_d   = c2_we;
      c2_d_s_d    = c2_d;
      c1_rd_cnt_d = c1_rd_cnt_q;
      c2_rd_cnt_d = c2_rd_cnt_q;
      c1_wr_cnt_d = c1_wr_cnt_q;
      c2_wr_cnt_d = c2_wr_cnt_q;
      done1_d     = done1_q;
      done2_d     = done2_q;
      if (clr) begin
         // Re-arm wins over everything, including requests sampled this cycle.
         c1_ce_s_d   = 1'b0;
         c1_we_s_d   = 1'b0;
         c1_addr_s_d = '0;
         c1_d_s_d    = '0;
         c2_ce_s_d   = 1'b0;
         c2_we_s_d   = 1'b0;
         c2_d_s_d    = '0;
         c1_rd_cnt_d = '0;
         c2_rd_cnt_d = '0;
         c1_wr_cnt_d = '0;
         c2_wr_cnt_d = '0;
         done1_d     = 1'b0;
         done2_d     = 1'b0;
      end else begin
         // The extra all-ones guard keeps the copy-1 read count from wrapping
         // when idx + CMP_LEN sits at the top of the counter range.
         if (c1_rd && (c1_rd_cnt_q <= c1_lim) && (c1_rd_cnt_q != CNT_MAX_C))
            c1_rd_cnt_d = c1_rd_cnt_q + ONE_C;
         if (c2_rd && (c2_rd_cnt_q < CMP_LEN_C))
            c2_rd_cnt_d = c2_rd_cnt_q + ONE_C;
         if (c1_wr && (c1_wr_cnt_q <= c1_last))
            c1_wr_cnt_d = c1_wr_cnt_q + ONE_C;
         if (c2_wr && (c2_wr_cnt_q <= CMP_LAST_C))
            c2_wr_cnt_d = c2_wr_cnt_q + ONE_C;
         if (c1_wr && !done1_q && (c1_wr_cnt_q == c1_last))
            done1_d = 1'b1;
         if (c2_wr && !done2_q && (c2_wr_cnt_q == CMP_LAST_C))
            done2_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c1_ce_s_q   <= 1'b0;
         c1_we_s_q   <= 1'b0;
         c1_addr_s_q <= '0;
         c1_d_s_q    <= '0;
         c2_ce_s_q   <= 1'b0;
         c2_we_s_q   <= 1'b0;
         c2_d_s_q    <= '0;
         c1_rd_cnt_q <= '0;
         c2_rd_cnt_q <= '0;
         c1_wr_cnt_q <= '0;
         c2_wr_cnt_q <= '0;
         done1_q     <= 1'b0;
         done2_q     <= 1'b0;
      end else begin
         c1_ce_s_q   <= c1_ce_s_d;
         c1_we_s_q   <= c1_we_s_d;
         c1_addr_s_q <= c1_addr_s_d;
         c1_d_s_q    <= c1_d_s_d;
         c2_ce_s_q   <= c2_ce_s_d;
         c2_we_s_q   <= c2_we_s_d;
         c2_d_s_q    <= c2_d_s_d;
         c1_rd_cnt_q <= c1_rd_cnt_d;
         c2_rd_cnt_q <= c2_rd_cnt_d;
         c1_wr_cnt_q <= c1_wr_cnt_d;
         c2_wr_cnt_q <= c2_wr_cnt_d;
         done1_q     <= done1_d;
         done2_q     <= done2_d;
      end
   end

   assign both_done = done1_q && done2_q;

   // Per-element capture slots. Copy 1's window is offset by idx, copy 2's
   // starts at its first write. A slot freezes once its copy is done.
   generate
      for (gi = 0; gi < CMP_LEN; gi++) begin : g_cap
         localparam logic [CNT_W-1:0] K_C = CNT_W'(gi);
         logic [DATA_W-1:0] cap1_q, cap1_d;
         logic [DATA_W-1:0] cap2_q, cap2_d;

         always_comb begin
            cap1_d = cap1_q;
            cap2_d = cap2_q;
            if (clr) begin
               cap1_d = '0;
               cap2_d = '0;
            end else begin
               if (c1_wr && !done1_q && (c1_wr_cnt_q == idx_ext + K_C))
                  cap1_d = c1_d_s_q;
               if (c2_wr && !done2_q && (c2_wr_cnt_q == K_C))
                  cap2_d = c2_d_s_q;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cap1_q <= '0;
               cap2_q <= '0;
            end else begin
               cap1_q <= cap1_d;
               cap2_q <= cap2_d;
            end
         end

         assign mismatch[gi] = both_done && (cap1_q != cap2_q);
      end
   endgenerate

   // Copy 2 reads the sequence in order from idx; the ADDR_W-bit sum wraps.
   assign c2_addr = idx + c2_rd_cnt_q[ADDR_W-1:0];

   assign c1_q    = c1_rd ? seq_arr[c1_addr_s_q] : free_in;
   assign c2_q    = seq_arr[c2_addr];
   assign c2_hold = (c2_rd_cnt_q == CMP_LAST_C);
   assign done1   = done1_q;
   assign done2   = done2_q;
   assign fc_fail = both_done && (mismatch != '0);

endmodule

// File: tb/tb_gqed_pair_monitor.sv
// Bench for gqed_pair_monitor: a default-parameter instance (CMP_LEN=2, idx=2)
// plus a CMP_LEN=4 instance (idx=14) for the wrap/saturation sequence.
// Expected output values are pushed to a scoreboard queue with a due cycle
// when stimulus is driven and compared when that cycle is reached.
module tb_gqed_pair_monitor;

   localparam int DW = 8;
   localparam int AW = 4;

   // scoreboard selectors
   localparam int S_C1Q   = 0;
   localparam int S_C2Q   = 1;
   localparam int S_HOLD  = 2;
   localparam int S_D1    = 3;
   localparam int S_D2    = 4;
   localparam int S_MM    = 5;
   localparam int S_FC    = 6;
   localparam int S_C2Q4  = 7;
   localparam int S_HOLD4 = 8;

   logic             clk = 1'b0;
   logic             rst_n, clr;
   logic [16*DW-1:0] seq;
   logic [AW-1:0]    idx, idx4;
   logic [DW-1:0]    free_in;

   logic             c1_ce, c1_we, c2_ce, c2_we;
   logic [AW-1:0]    c1_addr;
   logic [DW-1:0]    c1_d, c2_d, c1_q, c2_q;
   logic             c2_hold, done1, done2, fc_fail;
   logic [1:0]       mismatch;

   logic             c1_ce4, c1_we4, c2_ce4, c2_we4;
   logic [AW-1:0]    c1_addr4;
   logic [DW-1:0]    c1_d4, c2_d4, c1_q4, c2_q4;
   logic             c2_hold4, done1_4, done2_4, fc_fail4;
   logic [3:0]       mismatch4;

   gqed_pair_monitor #(.DATA_W(DW), .ADDR_W(AW), .CMP_LEN(2)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .seq(seq), .idx(idx), .free_in(free_in),
      .c1_ce(c1_ce), .c1_we(c1_we), .c1_addr(c1_addr), .c1_d(c1_d), .c1_q(c1_q),
      .c2_ce(c2_ce), .c2_we(c2_we), .c2_d(c2_d), .c2_q(c2_q), .c2_hold(c2_hold),
      .done1(done1), .done2(done2), .mismatch(mismatch), .fc_fail(fc_fail)
   );

   gqed_pair_monitor #(.DATA_W(DW), .ADDR_W(AW), .CMP_LEN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .seq(seq), .idx(idx4), .free_in(free_in),
      .c1_ce(c1_ce4), .c1_we(c1_we4), .c1_addr(c1_addr4), .c1_d(c1_d4), .c1_q(c1_q4),
      .c2_ce(c2_ce4), .c2_we(c2_we4), .c2_d(c2_d4), .c2_q(c2_q4), .c2_hold(c2_hold4),
      .done1(done1_4), .done2(done2_4), .mismatch(mismatch4), .fc_fail(fc_fail4)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
         $display("check %-12s got=%0h exp=%0h ok", tag, got, exp);
      end else begin
         $display("FAIL %-12s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         S_C1Q:   return 32'(c1_q);
         S_C2Q:   return 32'(c2_q);
         S_HOLD:  return 32'(c2_hold);
         S_D1:    return 32'(done1);
         S_D2:    return 32'(done2);
         S_MM:    return 32'(mismatch);
         S_FC:    return 32'(fc_fail);
         S_C2Q4:  return 32'(c2_q4);
         S_HOLD4: return 32'(c2_hold4);
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic expect_at(input string tag, input int sel, input logic [31:0] exp, input int lat);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      e.due = cyc + lat;
      sb_q.push_back(e);
   endtask

   task automatic check_due();
      int i;
      i = 0;
      while (i < sb_q.size()) begin
         if (sb_q[i].due <= cyc) begin
            check_eq(sb_q[i].tag, observe(sb_q[i].sel), sb_q[i].exp);
            sb_q.delete(i);
         end else begin
            i++;
         end
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      check_due();
   endtask

   task automatic idle();
      clr    = 1'b0;
      c1_ce  = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_d = '0;
      c2_ce  = 1'b0; c2_we = 1'b0; c2_d = '0;
      c1_ce4 = 1'b0; c1_we4 = 1'b0; c1_addr4 = '0; c1_d4 = '0;
      c2_ce4 = 1'b0; c2_we4 = 1'b0; c2_d4 = '0;
   endtask

   task automatic rearm();
      idle();
      clr = 1'b1;
      expect_at("rearm_done1", S_D1, 0, 1);
      expect_at("rearm_done2", S_D2, 0, 1);
      expect_at("rearm_fc", S_FC, 0, 1);
      tick();
      idle();
   endtask

   // Copy 1 writes 10,11,12,13 (window at idx=2 captures 12,13); copy 2 writes
   // 12 then c2b alongside the last two. clr_at: -1 none, 0 with the last
   // port write, 1 in the cycle after it.
   task automatic run_window(input logic [7:0] c2b, input int clr_at);
      logic bad;
      bad = (c2b != 8'd13);
      for (int k = 0; k < 4; k++) begin
         idle();
         c1_ce = 1'b1; c1_we = 1'b1; c1_d = 8'(10 + k);
         if (k >= 2) begin
            c2_ce = 1'b1; c2_we = 1'b1; c2_d = (k == 2) ? 8'd12 : c2b;
         end
         if (k == 3) begin
            clr = (clr_at == 0);
            expect_at("win_d1_early", S_D1, 0, 1);
            expect_at("win_d2_early", S_D2, 0, 1);
            if (clr_at < 0) begin
               expect_at("win_done1", S_D1, 1, 2);
               expect_at("win_done2", S_D2, 1, 2);
               expect_at("win_mismatch", S_MM, bad ? 32'd2 : 32'd0, 2);
               expect_at("win_fc_fail", S_FC, 32'(bad), 2);
            end else begin
               expect_at("clr_done1", S_D1, 0, 2);
               expect_at("clr_done2", S_D2, 0, 2);
               expect_at("clr_mismatch", S_MM, 0, 2);
               expect_at("clr_fc_fail", S_FC, 0, 2);
            end
         end
         tick();
      end
      idle();
      clr = (clr_at == 1);
      tick();
      idle();
      tick();
   endtask

   initial begin
      for (int k = 0; k < 16; k++) seq[k*DW +: DW] = 8'(k);
      idx     = 4'd2;
      idx4    = 4'd14;
      free_in = 8'hA5;
      idle();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      // reset state, checked while rst_n is low
      check_eq("rst_c1_q", 32'(c1_q), 32'hA5);
      check_eq("rst_c2_q", 32'(c2_q), 32'd2);
      check_eq("rst_c2_hold", 32'(c2_hold), 0);
      check_eq("rst_done1", 32'(done1), 0);
      check_eq("rst_done2", 32'(done2), 0);
      check_eq("rst_mismatch", 32'(mismatch), 0);
      check_eq("rst_fc_fail", 32'(fc_fail), 0);
      check_eq("rst_c2_q4", 32'(c2_q4), 32'd14);
      check_eq("rst_c2_hold4", 32'(c2_hold4), 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // copy-1 read path: read data the cycle after a read, free_in otherwise
      idle(); c1_ce = 1'b1; c1_addr = 4'd5;
      expect_at("c1_rd_addr5", S_C1Q, 32'd5, 1);
      tick();
      idle(); free_in = 8'h3C;
      expect_at("c1_free_in", S_C1Q, 32'h3C, 1);
      tick();
      idle(); c1_ce = 1'b1; c1_addr = 4'd15;
      expect_at("c1_rd_addr15", S_C1Q, 32'd15, 1);
      tick();
      idle();
      tick();

      // copy-2 sequence on both instances: wrap at 15->0 and saturation
      for (int r = 0; r < 6; r++) begin
         int n2, n4;
         n2 = (r < 2) ? r : 2;
         n4 = (r < 4) ? r : 4;
         idle();
         c2_ce = 1'b1; c2_ce4 = 1'b1;
         expect_at("c2_q_seq", S_C2Q, 32'(2 + n2), 1);
         expect_at("c2_hold", S_HOLD, 32'(n2 == 1), 1);
         expect_at("c2_q4_seq", S_C2Q4, 32'((14 + n4) % 16), 1);
         expect_at("c2_hold4", S_HOLD4, 32'(n4 == 3), 1);
         tick();
      end
      idle();
      tick();

      run_window(8'd13, -1);          // matching windows
      rearm();
      run_window(8'd99, -1);          // second element differs
      rearm();
      run_window(8'd13, 0);           // clr with the final writes
      run_window(8'd13, -1);
      rearm();
      run_window(8'd13, 1);           // clr on the capture edge
      run_window(8'd13, -1);
      rearm();
      run_window(8'd99, -1);

      // partial window, then asynchronous reset mid-cycle
      idle(); c1_ce = 1'b1; c1_we = 1'b1; c1_d = 8'd10;
      tick();
      idle(); c1_ce = 1'b1; c1_addr = 4'd7;
      tick();
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_done1", 32'(done1), 0);
      check_eq("mid_rst_done2", 32'(done2), 0);
      check_eq("mid_rst_mm", 32'(mismatch), 0);
      check_eq("mid_rst_fc", 32'(fc_fail), 0);
      check_eq("mid_rst_c1_q", 32'(c1_q), 32'(free_in));
      check_eq("mid_rst_c2_q", 32'(c2_q), 32'd2);
      check_eq("mid_rst_c2_q4", 32'(c2_q4), 32'd14);
      idle();
      @(negedge clk) rst_n = 1'b1;
      tick();
      run_window(8'd13, -1);          // full rerun after reset

      for (int i = 0; i < 20 && sb_q.size() > 0; i++) tick();
      check_eq("sb_drained", 32'(sb_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
